// File: rtl/sram_arb_pkg.sv
// Shared types for the FFT sample SRAM arbiter.
//   owner_t : identifies which requester issued an SRAM read (OWN_NONE for
//             idle cycles and writes); carried through the read-tag pipe.
//   mode_t  : arbitration mode; SHARED (host/dma round-robin, fft leftover)
//             or FFT_LOCK (fft owns the port exclusively).
package sram_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_HOST = 2'd1,
    OWN_DMA  = 2'd2,
    OWN_FFT  = 2'd3
  } owner_t;

  typedef enum logic {
    SHARED   = 1'b0,
    FFT_LOCK = 1'b1
  } mode_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Read-owner tag delay line. Each cycle the owner of the read issued this
// cycle (or OWN_NONE) enters at the head; it appears at tag_o exactly DEPTH
// cycles later, aligned with the SRAM read data.
// Ports:
//   clk_i  clock
//   clr_i  synchronous clear; empties every stage to OWN_NONE
//   tag_i  owner tag entering the pipe this cycle
//   tag_o  owner tag of the read whose data is on the SRAM bus now
module rd_tag_pipe
  import sram_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic   clk_i,
  input  logic   clr_i,
  input  owner_t tag_i,
  output owner_t tag_o
);

  owner_t pipe_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= OWN_NONE;
      end
    end else begin
      pipe_q[0] <= tag_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbiter owning the single-port FFT sample SRAM, shared by three requesters:
// host (CSR path), dma (write-back master) and fft (FFT core).
// In SHARED mode host and dma alternate round-robin under contention and fft
// gets cycles neither of them wants. Between fft_start and fft_done (or a
// lock timeout) fft owns the port exclusively. Read data is broadcast, with a
// per-requester rvalid that fires only for the requester that issued the read.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   fft_start / fft_done     1-cycle pulses entering / leaving FFT_LOCK
//   {h,d,f}_req/we/addr/wdata requester command, held until gnt
//   {h,d,f}_gnt              combinational same-cycle grant, at most one
//   {h,d,f}_rdata/rvalid     read return, RD_LATENCY cycles after the grant
//   sram_rden/wren/addr/wdata SRAM command (mux of the granted requester)
//   sram_rdata               SRAM read data, RD_LATENCY cycles after rden
//   fft_locked               high while in FFT_LOCK
//   lock_timeout             1-cycle pulse when the lock is forcibly released
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 9,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned RD_LATENCY   = 1,
  parameter int unsigned LOCK_TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fft_start,
  input  logic              fft_done,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_gnt,
  output logic [DATA_W-1:0] h_rdata,
  output logic              h_rvalid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rvalid,
  input  logic              f_req,
  input  logic              f_we,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic [DATA_W-1:0] f_wdata,
  output logic              f_gnt,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_rvalid,
  output logic              sram_rden,
  output logic              sram_wren,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              fft_locked,
  output logic              lock_timeout
);

  localparam int unsigned      CNT_W    = $clog2(LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  mode_t            mode_q;
  owner_t           rr_q;
  owner_t           rr_d;
  logic [CNT_W-1:0] lock_cnt_q;
  logic             lock_timeout_q;
  owner_t           rd_tag_d;
  owner_t           rd_tag_out;

  // Grant decision. Uses the registered mode, so a start/done pulse only
  // changes arbitration from the following cycle. Reset blocks all grants.
  always_comb begin
    h_gnt = 1'b0;
    d_gnt = 1'b0;
    f_gnt = 1'b0;
    if (!rst) begin
      if (mode_q == FFT_LOCK) begin
        f_gnt = f_req;
      end else if (h_req && d_req) begin
        if (rr_q == OWN_HOST) h_gnt = 1'b1;
        else                  d_gnt = 1'b1;
      end else if (h_req) begin
        h_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end else begin
        f_gnt = f_req;
      end
    end
  end

  // Round-robin pointer moves to the other shared requester after it is served.
  always_comb begin
    rr_d = rr_q;
    if (h_gnt)      rr_d = OWN_DMA;
    else if (d_gnt) rr_d = OWN_HOST;
  end

  // SRAM command mux; idle cycles drive all-zero address/data.
  always_comb begin
    sram_rden  = 1'b0;
    sram_wren  = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    rd_tag_d   = OWN_NONE;
    if (h_gnt) begin
      sram_rden  = !h_we;
      sram_wren  = h_we;
      sram_addr  = h_addr;
      sram_wdata = h_wdata;
      rd_tag_d   = h_we ? OWN_NONE : OWN_HOST;
    end else if (d_gnt) begin
      sram_rden  = !d_we;
      sram_wren  = d_we;
      sram_addr  = d_addr;
      sram_wdata = d_wdata;
      rd_tag_d   = d_we ? OWN_NONE : OWN_DMA;
    end else if (f_gnt) begin
      sram_rden  = !f_we;
      sram_wren  = f_we;
      sram_addr  = f_addr;
      sram_wdata = f_wdata;
      rd_tag_d   = f_we ? OWN_NONE : OWN_FFT;
    end
  end

  // Mode FSM with lock counter, timeout pulse and round-robin state.
  // fft_done takes priority over the timeout when both land in one cycle,
  // so a normal release is never reported as forced.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q         <= SHARED;
      lock_cnt_q     <= '0;
      lock_timeout_q <= 1'b0;
      rr_q           <= OWN_HOST;
    end else begin
      lock_timeout_q <= 1'b0;
      rr_q           <= rr_d;
      case (mode_q)
        SHARED: begin
          if (fft_start) begin
            mode_q     <= FFT_LOCK;
            lock_cnt_q <= '0;
          end
        end
        FFT_LOCK: begin
          lock_cnt_q <= lock_cnt_q + CNT_W'(1);
          if (fft_done) begin
            mode_q <= SHARED;
          end else if (lock_cnt_q == CNT_LAST) begin
            mode_q         <= SHARED;
            lock_timeout_q <= 1'b1;
          end
        end
        default: mode_q <= SHARED;
      endcase
    end
  end

  rd_tag_pipe #(
    .DEPTH(RD_LATENCY)
  ) u_rd_tag_pipe (
    .clk_i(clk),
    .clr_i(rst),
    .tag_i(rd_tag_d),
    .tag_o(rd_tag_out)
  );

  assign h_rdata  = sram_rdata;
  assign d_rdata  = sram_rdata;
  assign f_rdata  = sram_rdata;
  assign h_rvalid = !rst && (rd_tag_out == OWN_HOST);
  assign d_rvalid = !rst && (rd_tag_out == OWN_DMA);
  assign f_rvalid = !rst && (rd_tag_out == OWN_FFT);

  assign fft_locked   = (mode_q == FFT_LOCK);
  assign lock_timeout = lock_timeout_q;

endmodule
